// File: rtl/icap_stream_ctrl.sv
// icap_stream_ctrl -- streams a programmed number of configuration words from a
// standard (non-FWFT) FIFO into the ICAP primitive, with underrun timeout,
// explicit abort sequence and done/error reporting.
//
// Optional build macro: ICAP_BITSWAP_EN -- reverse the bit order inside every
// byte lane of fifo_dout before it is registered onto icap_din.
//
// Ports:
//   clock          system clock, rising edge
//   reset          synchronous, active-low reset
//   start          pulse, begins a transfer (IDLE only)
//   abort          pulse, requests an abort (STREAM only)
//   word_total     words to transfer, sampled on an accepted start
//   fifo_empty     FIFO empty flag
//   fifo_dout      FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en     FIFO read enable
//   icap_csib      ICAP chip select, active-low
//   icap_rdwrb     ICAP read/write select, 0 = write
//   icap_din       ICAP write data
//   words_written  words presented to ICAP since the last accepted start
//   busy           high outside IDLE
//   done           one-cycle pulse on successful completion
//   error          sticky abort/timeout flag, cleared by the next start
module icap_stream_ctrl #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned CNT_WIDTH      = 24,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CNT_WIDTH-1:0]  word_total,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  icap_csib,
  output logic                  icap_rdwrb,
  output logic [DATA_WIDTH-1:0] icap_din,
  output logic [CNT_WIDTH-1:0]  words_written,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_ABORT, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  total_q, reads_q, ww_q, ww_inc;
  logic [STALL_W-1:0]    stall_q, stall_inc;
  logic [1:0]            ab_q;
  logic                  v1_q;   // fifo_dout carries a word for the stream this cycle
  logic                  wr_q;   // icap_din holds a word to write this cycle
  logic                  error_q;
  logic [DATA_WIDTH-1:0] din_q, din_next;
  logic                  reads_left, stall_hit;

`ifdef ICAP_BITSWAP_EN
  always_comb begin
    din_next = '0;
    for (int unsigned b = 0; b < DATA_WIDTH / 8; b++) begin
      for (int unsigned i = 0; i < 8; i++) begin
        din_next[b*8 + i] = fifo_dout[b*8 + 7 - i];
      end
    end
  end
`else
  assign din_next = fifo_dout;
`endif

  always_comb begin
    state_d    = state_q;
    fifo_rd_en = 1'b0;
    icap_csib  = 1'b1;
    icap_rdwrb = 1'b1;
    stall_hit  = 1'b0;
    ww_inc     = ww_q + CNT_WIDTH'(1);
    stall_inc  = stall_q + STALL_W'(1);
    reads_left = (reads_q < total_q);
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = (word_total == '0) ? S_DONE : S_STREAM;
      end
      S_STREAM: begin
        fifo_rd_en = ~fifo_empty & reads_left;
        stall_hit  = fifo_empty & reads_left & (stall_inc == STALL_MAX);
        icap_csib  = ~wr_q;
        icap_rdwrb = ~wr_q;
        // abort/timeout take priority over a coinciding final write
        if (abort || stall_hit)                 state_d = S_ABORT;
        else if (wr_q && (ww_inc == total_q))   state_d = S_DONE;
      end
      S_ABORT: begin
        // A0 deselects, A1..A3 form the abort signature (csib low, rdwrb high)
        icap_csib = (ab_q == 2'd0);
        if (ab_q == 2'd3) state_d = S_IDLE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      total_q <= '0;
      reads_q <= '0;
      ww_q    <= '0;
      stall_q <= '0;
      ab_q    <= '0;
      v1_q    <= 1'b0;
      wr_q    <= 1'b0;
      error_q <= 1'b0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        total_q <= word_total;
        reads_q <= '0;
        ww_q    <= '0;
        stall_q <= '0;
        error_q <= 1'b0;
      end
      if (state_q == S_STREAM) begin
        if (fifo_rd_en) begin
          reads_q <= reads_q + CNT_WIDTH'(1);
          stall_q <= '0;
        end else if (fifo_empty && reads_left) begin
          stall_q <= stall_inc;
        end
        if (wr_q && (ww_q != total_q)) ww_q <= ww_inc;
        if (state_d == S_ABORT) error_q <= 1'b1;
      end
      // Leaving STREAM flushes the two-stage pipeline: in-flight words are dropped
      // and icap_din keeps the last word actually written.
      v1_q <= fifo_rd_en && (state_d == S_STREAM);
      wr_q <= v1_q && (state_d == S_STREAM);
      if (v1_q && state_q == S_STREAM && state_d == S_STREAM) din_q <= din_next;
      ab_q <= (state_q == S_ABORT) ? ab_q + 2'd1 : 2'd0;
    end
  end

  assign icap_din      = din_q;
  assign words_written = ww_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign error         = error_q;

endmodule

// File: tb/tb_icap_stream_ctrl.sv
// Self-checking bench for icap_stream_ctrl: directed scenarios plus randomized
// transfers, compared cycle by cycle against a transaction-level reference that
// schedules each read as an ICAP write two cycles later.
module tb_icap_stream_ctrl;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int TO = 16;

  logic          clock = 1'b0;
  logic          reset, start, abort, fifo_empty;
  logic [CW-1:0] word_total;
  logic [DW-1:0] fifo_dout;
  logic          fifo_rd_en, icap_csib, icap_rdwrb, busy, done, error;
  logic [DW-1:0] icap_din;
  logic [CW-1:0] words_written;

  always #5 clock = ~clock;

  icap_stream_ctrl #(
    .DATA_WIDTH    (DW),
    .CNT_WIDTH     (CW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .word_total   (word_total),
    .fifo_empty   (fifo_empty),
    .fifo_dout    (fifo_dout),
    .fifo_rd_en   (fifo_rd_en),
    .icap_csib    (icap_csib),
    .icap_rdwrb   (icap_rdwrb),
    .icap_din     (icap_din),
    .words_written(words_written),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  typedef struct { int due; logic [DW-1:0] data; } wr_t;

  int tests = 0, fails = 0;
  logic [DW-1:0] fq[$];   // bench-side FIFO contents
  wr_t pend[$];           // reads awaiting their ICAP write slot
  int m_st;               // 0 idle, 1 stream, 2 abort, 3 done
  int m_total, m_reads, m_written, m_stall, m_abcnt, cyc;
  bit m_err, chk_en;
  logic [DW-1:0] m_din, last_wdin;
  int n_rd, n_wr, n_done, first_rd, first_wr, last_wr, done_cyc;

  function automatic logic [DW-1:0] swap_ref(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i++) r[i] = d[(i / 8) * 8 + 7 - (i % 8)];
    return r;
  endfunction

  function automatic logic [DW-1:0] icap_word(input logic [DW-1:0] d);
`ifdef ICAP_BITSWAP_EN
    return swap_ref(d);
`else
    return d;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input logic [DW-1:0] d);
    fq.push_back(d);
    fifo_empty = 1'b0;
  endtask

  task automatic flush_fifo();
    fq.delete();
    fifo_empty = 1'b1;
  endtask

  task automatic clr_counts();
    n_rd = 0; n_wr = 0; n_done = 0;
    first_rd = -1; first_wr = -1; last_wr = -1; done_cyc = -1;
  endtask

  task automatic model_reset();
    m_st = 0; m_total = 0; m_reads = 0; m_written = 0; m_stall = 0; m_abcnt = 0;
    m_err = 0; m_din = '0;
    pend.delete();
  endtask

  // One clock cycle: compare at the falling edge, then advance FIFO and reference.
  task automatic tick(input bit st, input bit ab);
    bit exp_rd, wr_now, act_rd, pre_empty;
    logic [DW-1:0] popped;
    wr_t w;
    start = st;
    abort = ab;
    @(negedge clock);
    pre_empty = fifo_empty;
    exp_rd = (m_st == 1) && !fifo_empty && (m_reads < m_total);
    wr_now = (m_st == 1) && (pend.size() > 0) && (pend[0].due == cyc);
    if (wr_now) m_din = pend[0].data;
    if (chk_en) begin
      chk("fifo_rd_en", {31'd0, fifo_rd_en}, {31'd0, exp_rd});
      chk("icap_csib", {31'd0, icap_csib}, {31'd0, !(wr_now || (m_st == 2 && m_abcnt > 0))});
      chk("icap_rdwrb", {31'd0, icap_rdwrb}, {31'd0, !wr_now});
      chk("busy", {31'd0, busy}, {31'd0, m_st != 0});
      chk("done", {31'd0, done}, {31'd0, m_st == 3});
      chk("error", {31'd0, error}, {31'd0, m_err});
      chk("words_written", {16'd0, words_written}, m_written);
      chk("icap_din", icap_din, m_din);
    end
    act_rd = fifo_rd_en;
    if (act_rd) begin
      n_rd++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (!icap_csib && !icap_rdwrb) begin
      n_wr++;
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      last_wdin = icap_din;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    @(posedge clock);
    #1;
    popped = '0;
    if (act_rd && fq.size() > 0) popped = fq.pop_front();
    if (act_rd) fifo_dout = popped;
    fifo_empty = (fq.size() == 0);
    if (!reset) begin
      model_reset();
    end else begin
      case (m_st)
        0: if (st) begin
          m_total = int'(word_total); m_reads = 0; m_written = 0; m_stall = 0; m_err = 0;
          m_st = (word_total == '0) ? 3 : 1;
        end
        1: begin
          if (exp_rd) begin
            w.due = cyc + 2;
            w.data = icap_word(popped);
            pend.push_back(w);
            m_reads++;
            m_stall = 0;
          end else if (pre_empty && m_reads < m_total) begin
            m_stall++;
          end
          if (wr_now) begin
            void'(pend.pop_front());
            m_written++;
          end
          if (ab || m_stall == TO) begin
            m_st = 2; m_err = 1; m_abcnt = 0;
            pend.delete();
          end else if (m_written == m_total) begin
            m_st = 3;
          end
        end
        2: if (m_abcnt == 3) m_st = 0; else m_abcnt++;
        default: m_st = 0;
      endcase
    end
    cyc++;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd_en"}, {31'd0, fifo_rd_en}, 32'd0);
    chk({tag, "_csib"}, {31'd0, icap_csib}, 32'd1);
    chk({tag, "_rdwrb"}, {31'd0, icap_rdwrb}, 32'd1);
    chk({tag, "_din"}, icap_din, 32'd0);
    chk({tag, "_ww"}, {16'd0, words_written}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_error"}, {31'd0, error}, 32'd0);
  endtask

  initial begin
    int wt, lim, pushed, sc;
    bit ab;
    logic [DW-1:0] bs_exp;
    reset = 1'b0; start = 1'b0; abort = 1'b0; word_total = '0;
    fifo_empty = 1'b1; fifo_dout = '0; chk_en = 0; cyc = 0; last_wdin = '0;
    model_reset();
    clr_counts();

    // Reset
    tick(0, 0);
    tick(0, 0);
    reset = 1'b1;
    chk_reset_vals("reset");
    chk_en = 1;
    tick(0, 0);

    // Basic 4-word transfer
    for (int i = 0; i < 4; i++) push($urandom);
    clr_counts();
    word_total = 16'd4;
    tick(1, 0);
    repeat (10) tick(0, 0);
    chk("basic_reads", n_rd, 4);
    chk("basic_writes", n_wr, 4);
    chk("basic_latency", first_wr - first_rd, 2);
    chk("basic_backtoback", last_wr - first_wr, 3);
    chk("basic_done_cnt", n_done, 1);
    chk("basic_done_time", done_cyc - last_wr, 1);
    chk("basic_ww", {16'd0, words_written}, 32'd4);
    chk("basic_error", {31'd0, error}, 32'd0);

    // Zero length
    clr_counts();
    word_total = '0;
    sc = cyc;
    tick(1, 0);
    repeat (4) tick(0, 0);
    chk("zero_done_time", done_cyc - sc, 1);
    chk("zero_reads", n_rd, 0);
    chk("zero_writes", n_wr, 0);

    // Underrun: 3 of 8 words supplied
    flush_fifo();
    for (int i = 0; i < 3; i++) push($urandom);
    clr_counts();
    word_total = 16'd8;
    tick(1, 0);
    repeat (30) tick(0, 0);
    chk("underrun_writes", n_wr, 3);
    chk("underrun_done", n_done, 0);
    chk("underrun_error", {31'd0, error}, 32'd1);
    chk("underrun_idle", {31'd0, busy}, 32'd0);

    // User abort coinciding with the 10th write
    flush_fifo();
    for (int i = 0; i < 20; i++) push($urandom);
    clr_counts();
    word_total = 16'd100;
    tick(1, 0);
    for (int k = 0; k < 40; k++) begin
      ab = (m_st == 1) && (pend.size() > 0) && (pend[0].due == cyc) && (m_written == 9);
      tick(0, ab);
      if (ab) break;
    end
    repeat (6) tick(0, 0);
    chk("abort_ww", {16'd0, words_written}, 32'd10);
    chk("abort_writes", n_wr, 10);
    chk("abort_dropped_le2", {31'd0, (n_rd - n_wr) <= 2}, 32'd1);
    chk("abort_error", {31'd0, error}, 32'd1);
    word_total = 16'd3;
    tick(1, 0);
    chk("abort_err_clear", {31'd0, error}, 32'd0);
    repeat (8) tick(0, 0);

    // Randomized transfers with gaps, short supply and random aborts
    for (int it = 0; it < 16; it++) begin
      flush_fifo();
      wt = $urandom_range(1, 12);
      lim = ($urandom_range(0, 3) == 0) ? $urandom_range(0, wt - 1) : wt;
      pushed = 0;
      word_total = CW'(wt);
      if (lim > 0 && $urandom_range(0, 1) == 1) begin
        push($urandom);
        pushed++;
      end
      tick(1, 0);
      for (int k = 0; k < 200 && m_st != 0; k++) begin
        if (pushed < lim && $urandom_range(0, 9) < 7) begin
          push($urandom);
          pushed++;
        end
        tick(0, $urandom_range(0, 59) == 0);
      end
      chk("rand_idle", {31'd0, busy}, 32'd0);
    end

    // Reset mid-stream
    flush_fifo();
    for (int i = 0; i < 10; i++) push($urandom);
    word_total = 16'd10;
    tick(1, 0);
    repeat (4) tick(0, 0);
    reset = 1'b0;
    tick(0, 0);
    reset = 1'b1;
    chk_reset_vals("midreset");
    repeat (3) tick(0, 0);

    // Bit order of a known word
    flush_fifo();
    push(32'h01020380);
    clr_counts();
    word_total = 16'd1;
    tick(1, 0);
    repeat (5) tick(0, 0);
`ifdef ICAP_BITSWAP_EN
    bs_exp = 32'h8040C001;
`else
    bs_exp = 32'h01020380;
`endif
    chk("bitswap_writes", n_wr, 1);
    chk("bitswap_din", last_wdin, bs_exp);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
